fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage at the head of the 5-stage RV64 pipeline. Holds the PC, issues 32-bit instruction reads on the instruction bus with an addr_ok/data_ok split handshake, and hands `{pc, raw_instr}` to decode over a valid/ready interface. Decode builds the fetch-data record from this output. Handles redirects from execute (branch/jump) or the trap logic, including redirects that arrive while a bus transaction is in flight.

## Interface
- `PC_RESET`, default 64'h8000_0000: first fetch address after reset.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ireq_valid` out 1: instruction-bus request valid.
- `ireq_addr` out 64: request address; stable while `ireq_valid` is high and `iresp_addr_ok` is low.
- `iresp_addr_ok` in 1: request accepted this cycle.
- `iresp_data_ok` in 1: read data valid this cycle.
- `iresp_data` in 32: instruction word.
- `redirect_valid` in 1: one-cycle pulse requesting a fetch from `redirect_pc`.
- `redirect_pc` in 64: redirect target.
- `out_valid` out 1: instruction available to decode.
- `out_ready` in 1: decode accepts this cycle.
- `out_pc` out 64: PC of the delivered instruction.
- `out_instr` out 32: raw instruction.
- `out_exc` out 1: instruction-address-misaligned flag (see Configuration).

## Operation
- States: IDLE, REQ, DATA, HOLD. Registers: `pc`, `drop`, `next_pc`.
- IDLE: the reset state. Go to REQ on the next cycle.
- REQ:
  - `ireq_valid`=1, `ireq_addr`=`pc`.
  - On `iresp_addr_ok`, go to DATA.
- DATA:
  - On `iresp_data_ok` with `drop`=0: latch data into `out_instr`, set `out_pc`=`pc`, go to HOLD.
  - On `iresp_data_ok` with `drop`=1: discard the data, set `pc`=`next_pc`, clear `drop`, go to REQ.
- HOLD:
  - `out_valid`=1.
  - On `out_ready`: set `pc`=`pc`+4 (64-bit wrap), go to REQ.
- Redirect in REQ or DATA:
  - The bus transaction is never retracted and `ireq_addr` stays unchanged.
  - Set `drop`=1 and `next_pc`=`redirect_pc`.
  - If a REQ redirect coincides with `addr_ok`, the request still moves to DATA and is dropped.
- Redirect in HOLD:
  - Go to REQ with `pc`=`redirect_pc`; `out_valid` falls next cycle.
  - If `out_ready` is also high that cycle, the handshake counts as delivered. The redirect source is responsible for flushing that instruction downstream. The redirect wins over `pc`+4.
- Redirect in IDLE: `pc`=`redirect_pc`, then go to REQ.
- Multiple redirects before a drop resolves: the last `redirect_pc` wins.
- `out_pc`, `out_instr` and `out_exc` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values:
  - `ireq_valid`=0, `ireq_addr`=`PC_RESET`, `out_valid`=0, `out_pc`=0, `out_instr`=0, `out_exc`=0.
  - State IDLE, `pc`=`PC_RESET`, `drop`=0.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- First cycle after `reset_n` deasserts: IDLE. Second cycle: `ireq_valid`=1.
- Zero-wait bus (`addr_ok` in REQ, `data_ok` the following cycle):
  - `out_valid` is high 2 cycles after the REQ cycle.
  - Peak throughput is 1 instruction per 3 cycles.
- Redirect resolving a drop: the new REQ is issued the cycle after the dropped `data_ok`.
- Asserting `reset_n` low mid-transaction aborts immediately. The instruction bus shares `reset_n`, so no stale `data_ok` appears after reset.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - When entering REQ, if `pc[1:0]`≠0, no bus request is issued.
  - Go directly to HOLD with `out_exc`=1, `out_pc`=`pc`, `out_instr`=32'h0000_0013 (nop).
  - The trap logic is expected to redirect.
- `FETCH_MISALIGN_CHECK_EN` undefined:
  - `out_exc` is tied to 0.
  - `ireq_addr` is forced to `{pc[63:2], 2'b00}`.
  - `out_pc` reports the unmasked `pc`.

## Test plan
- Reset release, zero-wait bus returning 32'h0000_0093:
  - `ireq_addr`=8000_0000 on cycle 2.
  - `out_valid` with `out_pc`=8000_0000 and `out_instr`=0000_0093 on cycle 4.
  - Next request is to 8000_0004.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD -> `out_valid`, `out_pc` and `out_instr` stay constant and `ireq_valid` stays 0.
- Redirect to 8000_0100 while in DATA for 8000_0008:
  - The 8000_0008 data is never presented on `out_valid`.
  - The next `ireq_addr` is 8000_0100.
- Redirect to 8000_0200 in the same cycle as `out_ready` in HOLD -> the next request is 8000_0200, not `pc`+4.
- `addr_ok` delayed 3 cycles with a redirect on the second of them -> `ireq_addr` stays at the old PC until `addr_ok`, then that transaction is dropped.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 8000_0102 -> no bus request; `out_valid` with `out_exc`=1 and `out_pc`=8000_0102. Without the macro, `ireq_addr`=8000_0100.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, split addr_ok/data_ok bus handshake, valid/ready hand-off to decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: raise an address-misaligned exception instead of fetching.
module fetch_stage #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, HOLD} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [63:0] next_pc_q;
  logic        drop_q;
  logic [63:0] out_pc_q;
  logic [31:0] out_instr_q;
  logic [63:0] pc_inc_d;
  logic        misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic out_exc_q;
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign ireq_addr  = pc_q;
  assign out_exc    = out_exc_q;
`else
  assign misaligned = 1'b0;
  assign ireq_addr  = {pc_q[63:2], 2'b00};
  assign out_exc    = 1'b0;
`endif

  assign pc_inc_d   = pc_q + 64'd4;
  assign ireq_valid = (state_q == REQ) && !misaligned;
  assign out_valid  = (state_q == HOLD);
  assign out_pc     = out_pc_q;
  assign out_instr  = out_instr_q;

  // A redirect during REQ/DATA cannot retract the bus transaction, so it is
  // parked in next_pc_q and the in-flight response is discarded on arrival.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= PC_RESET;
      next_pc_q   <= PC_RESET;
      drop_q      <= 1'b0;
      out_pc_q    <= 64'd0;
      out_instr_q <= 32'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
      out_exc_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_valid) pc_q <= redirect_pc;
          state_q <= REQ;
        end
        REQ: begin
          if (misaligned) begin
            if (redirect_valid) begin
              pc_q <= redirect_pc;
            end else begin
              out_pc_q    <= pc_q;
              out_instr_q <= 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHECK_EN
              out_exc_q   <= 1'b1;
`endif
              state_q     <= HOLD;
            end
          end else begin
            if (redirect_valid) begin
              drop_q    <= 1'b1;
              next_pc_q <= redirect_pc;
            end
            if (iresp_addr_ok) state_q <= DATA;
          end
        end
        DATA: begin
          if (iresp_data_ok) begin
            // A redirect arriving with the data is newer than any parked target.
            if (redirect_valid) begin
              pc_q    <= redirect_pc;
              drop_q  <= 1'b0;
              state_q <= REQ;
            end else if (drop_q) begin
              pc_q    <= next_pc_q;
              drop_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              out_pc_q    <= pc_q;
              out_instr_q <= iresp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
              out_exc_q   <= 1'b0;
`endif
              state_q     <= HOLD;
            end
          end else if (redirect_valid) begin
            drop_q    <= 1'b1;
            next_pc_q <= redirect_pc;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= REQ;
          end else if (out_ready) begin
            pc_q    <= pc_inc_d;
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: bus responder, delivery scoreboard with a PC-based instruction model,
// per-cycle protocol checks and literal checks taken from the fetch test scenarios.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;

  int checks = 0;
  int errors = 0;
  int addrDelay = 0;
  int dataDelay = 0;
  int reqCount = 0;
  logic [63:0] expQ[$];

  fetch_stage #(.PC_RESET(64'h8000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    logic [31:0] off;
    off = a[31:0] - 32'h8000_0000;
    return 32'h0000_0093 | (off << 12);
  endfunction

  function automatic logic [31:0] expInstr(input logic [63:0] pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    if (pc[1:0] != 2'b00) return 32'h0000_0013;
`endif
    return memWord({pc[63:2], 2'b00});
  endfunction

  function automatic logic expExc(input logic [63:0] pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    return pc[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  task automatic waitReq(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ireq_valid) return;
    end
    timeoutFail(name);
  endtask

  task automatic waitValid(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    timeoutFail(name);
  endtask

  // Bus slave: grants after addrDelay waiting cycles, returns data dataDelay cycles after the grant cycle's successor.
  initial begin
    logic        pend;
    logic [63:0] pendAddr;
    int          dataCnt;
    int          waitCnt;
    pend = 1'b0; pendAddr = '0; dataCnt = 0; waitCnt = 0;
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (!reset_n) begin
        pend = 1'b0; waitCnt = 0;
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
      end else begin
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        if (pend) begin
          if (dataCnt == 0) begin
            iresp_data_ok = 1'b1;
            iresp_data    = memWord(pendAddr);
            pend          = 1'b0;
          end else begin
            dataCnt--;
          end
        end
        if (ireq_valid) begin
          if (waitCnt >= addrDelay) begin
            iresp_addr_ok = 1'b1;
            pend          = 1'b1;
            pendAddr      = ireq_addr;
            dataCnt       = dataDelay;
            waitCnt       = 0;
          end else begin
            waitCnt++;
          end
        end
      end
    end
  end

  // Per-cycle compare: deliveries against the scoreboard, plus hold/stability rules.
  initial begin
    logic        pOv, pOr, pRd, pExc, pIv, pAok;
    logic [63:0] pPc, pAddr, e;
    logic [31:0] pInstr;
    pOv = 0; pOr = 0; pRd = 0; pExc = 0; pIv = 0; pAok = 0; pPc = '0; pAddr = '0; pInstr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        if (ireq_valid) reqCount++;
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            timeoutFail("unexpectedDelivery");
          end else begin
            e = expQ.pop_front();
            checkOutput("deliverPc", out_pc, e);
            checkOutput("deliverInstr", {32'd0, out_instr}, {32'd0, expInstr(e)});
            checkOutput("deliverExc", {63'd0, out_exc}, {63'd0, expExc(e)});
          end
        end
        if (out_valid) checkOutput("noReqInHold", {63'd0, ireq_valid}, 64'd0);
`ifndef FETCH_MISALIGN_CHECK_EN
        if (ireq_valid) checkOutput("reqAligned", {62'd0, ireq_addr[1:0]}, 64'd0);
`endif
        if (pOv && !pOr && !pRd) begin
          checkOutput("holdValid", {63'd0, out_valid}, 64'd1);
          checkOutput("holdPc", out_pc, pPc);
          checkOutput("holdInstr", {32'd0, out_instr}, {32'd0, pInstr});
          checkOutput("holdExc", {63'd0, out_exc}, {63'd0, pExc});
        end
        if (pIv && !pAok) begin
          checkOutput("reqHeld", {63'd0, ireq_valid}, 64'd1);
          checkOutput("reqAddrStable", ireq_addr, pAddr);
        end
        pOv = out_valid; pOr = out_ready; pRd = redirect_valid; pPc = out_pc;
        pInstr = out_instr; pExc = out_exc; pIv = ireq_valid; pAok = iresp_addr_ok; pAddr = ireq_addr;
      end else begin
        pOv = 0; pIv = 0;
      end
    end
  end

  task automatic applyStimulus(input logic rdv, input logic [63:0] rpc, input logic rdy);
    redirect_valid = rdv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  initial begin
    int snap;
    reset_n = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rstIreqValid", {63'd0, ireq_valid}, 64'd0);
    checkOutput("rstIreqAddr", ireq_addr, 64'h8000_0000);
    checkOutput("rstOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("rstOutPc", out_pc, 64'd0);
    checkOutput("rstOutInstr", {32'd0, out_instr}, 64'd0);
    checkOutput("rstOutExc", {63'd0, out_exc}, 64'd0);

    // Reset release with a zero-wait bus.
    reset_n = 1'b1;
    expQ.push_back(64'h8000_0000);
    applyStimulus(1'b0, 64'd0, 1'b1);
    checkOutput("c1IdleNoReq", {63'd0, ireq_valid}, 64'd0);
    @(negedge clk);
    checkOutput("c2ReqValid", {63'd0, ireq_valid}, 64'd1);
    checkOutput("c2ReqAddr", ireq_addr, 64'h8000_0000);
    @(negedge clk);
    checkOutput("c3NoValid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    checkOutput("c4OutValid", {63'd0, out_valid}, 64'd1);
    checkOutput("c4OutPc", out_pc, 64'h8000_0000);
    checkOutput("c4OutInstr", {32'd0, out_instr}, 64'h0000_0093);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("c5ReqAddr", ireq_addr, 64'h8000_0004);

    // Backpressure for five cycles in HOLD.
    waitValid("waitHold0004");
    checkOutput("bpPc", out_pc, 64'h8000_0004);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpValid", {63'd0, out_valid}, 64'd1);
      checkOutput("bpInstr", {32'd0, out_instr}, 64'h0000_4093);
      checkOutput("bpNoReq", {63'd0, ireq_valid}, 64'd0);
    end
    expQ.push_back(64'h8000_0004);
    out_ready = 1'b1;
    dataDelay = 2;
    @(negedge clk);
    out_ready = 1'b0;

    // Redirect while DATA for 8000_0008 is outstanding.
    checkOutput("r1ReqAddr", ireq_addr, 64'h8000_0008);
    @(negedge clk);
    applyStimulus(1'b1, 64'h8000_0100, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 64'd0, 1'b0);
    dataDelay = 0;
    waitReq("waitReq0100");
    checkOutput("r1NextReq", ireq_addr, 64'h8000_0100);

    // Redirect coinciding with out_ready in HOLD.
    waitValid("waitHold0100");
    expQ.push_back(64'h8000_0100);
    applyStimulus(1'b1, 64'h8000_0200, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 64'd0, 1'b0);
    checkOutput("r2ValidFell", {63'd0, out_valid}, 64'd0);
    checkOutput("r2ReqAddr", ireq_addr, 64'h8000_0200);
    waitValid("waitHold0200");
    expQ.push_back(64'h8000_0200);
    out_ready = 1'b1;
    addrDelay = 3;
    @(negedge clk);
    out_ready = 1'b0;

    // addr_ok delayed three cycles, redirect on the second waiting cycle.
    checkOutput("r3W1Addr", ireq_addr, 64'h8000_0204);
    @(negedge clk);
    checkOutput("r3W2Addr", ireq_addr, 64'h8000_0204);
    applyStimulus(1'b1, 64'h8000_0300, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 64'd0, 1'b0);
    checkOutput("r3W3Addr", ireq_addr, 64'h8000_0204);
    @(negedge clk);
    checkOutput("r3W4Valid", {63'd0, ireq_valid}, 64'd1);
    checkOutput("r3W4Addr", ireq_addr, 64'h8000_0204);
    addrDelay = 0;
    waitReq("waitReq0300");
    checkOutput("r3NextReq", ireq_addr, 64'h8000_0300);
    waitValid("waitHold0300");
    expQ.push_back(64'h8000_0300);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Misaligned redirect target.
    waitValid("waitHold0304");
    expQ.push_back(64'h8000_0304);
    applyStimulus(1'b1, 64'h8000_0102, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 64'd0, 1'b0);
    snap = reqCount;
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("maNoReq", {63'd0, ireq_valid}, 64'd0);
`else
    checkOutput("maReqValid", {63'd0, ireq_valid}, 64'd1);
    checkOutput("maReqAddr", ireq_addr, 64'h8000_0100);
`endif
    waitValid("waitHold0102");
    checkOutput("maOutPc", out_pc, 64'h8000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("maOutExc", {63'd0, out_exc}, 64'd1);
    checkOutput("maOutInstr", {32'd0, out_instr}, 64'h0000_0013);
    checkOutput("maReqCount", reqCount, snap);
`else
    checkOutput("maOutExc", {63'd0, out_exc}, 64'd0);
    checkOutput("maOutInstr", {32'd0, out_instr}, 64'h0010_0093);
`endif
    expQ.push_back(64'h8000_0102);
    applyStimulus(1'b1, 64'h8000_0400, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 64'd0, 1'b0);
    checkOutput("r4ReqAddr", ireq_addr, 64'h8000_0400);
    waitValid("waitHold0400");
    expQ.push_back(64'h8000_0400);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", expQ.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
